// File: rtl/lcd_de_rx.sv
// lcd_de_rx: DE-mode parallel RGB LCD receiver with frame timing lock and a 2-entry pixel buffer.
// Ports: pixel_clk/rst (async, active-high); de_in, red_in, green_in, blue_in: sampled video;
//        pix_valid/pix_ready/pix_data/pix_x/pix_y/pix_sof/pix_eol: pixel stream out;
//        locked, meas_width, meas_height, frame_cnt, err_cnt, overflow: timing status;
//        frame_crc: previous frame CRC-16-CCITT when LCD_DE_RX_FRAME_CRC_EN is defined, else 0.
module lcd_de_rx #(
    parameter int VGAP_MIN = 400,
    parameter int GAP_W    = 12,
    parameter int ERR_W    = 8
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             de_in,
    input  logic [7:0]       red_in,
    input  logic [7:0]       green_in,
    input  logic [7:0]       blue_in,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [23:0]      pix_data,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             locked,
    output logic [9:0]       meas_width,
    output logic [9:0]       meas_height,
    output logic [15:0]      frame_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             overflow,
    output logic [15:0]      frame_crc
);
    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;
    state_t state, state_nx;
    logic             in_v, armed, de_r;
    logic [23:0]      rgb_r;
    logic [GAP_W-1:0] gap;
    logic             s_de, s_sof;
    logic [23:0]      s_data;
    logic [9:0]       s_x, s_y;
    logic             fresh, need_w, frame_bad;
    logic [45:0]      mem [2];
    logic             rd, wr;
    logic [1:0]       cnt;
    logic             rise, sof_det, fall, len_bad, h_bad, drop_lock, push, pop, acc;
    logic [9:0]       len, height;

    // armed blocks a DE rise that is only an artefact of reset (DE already high when rst released)
    assign rise      = de_r & ~s_de;
    assign sof_det   = rise & armed & (gap >= GAP_W'(VGAP_MIN));
    assign fall      = s_de & ~de_r;
    assign len       = s_x + 10'd1;
    assign height    = s_y + 10'd1;
    assign len_bad   = len != meas_width;
    assign h_bad     = height != meas_height;
    assign drop_lock = (state == LOCKED) & ((sof_det & h_bad) | (fall & len_bad));
    assign push      = s_de & (state != SEARCH);
    assign pix_valid = cnt != 2'd0;
    assign pop       = pix_valid & pix_ready;
    assign acc       = push & (~cnt[1] | pop);
    assign {pix_data, pix_x, pix_y, pix_sof, pix_eol} = mem[rd];

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            in_v  <= 1'b0;
            armed <= 1'b0;
            de_r  <= 1'b0;
            rgb_r <= '0;
            gap   <= '1;
        end else begin
            in_v  <= 1'b1;
            armed <= armed | (in_v & ~de_r);
            de_r  <= de_in;
            rgb_r <= {red_in, green_in, blue_in};
            gap   <= de_r ? '0 : gap + GAP_W'(~&gap);
        end
    end

    // second stage holds the pixel one cycle so de_r can tell whether it ends the line
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            s_de   <= 1'b0;
            s_sof  <= 1'b0;
            s_data <= '0;
            s_x    <= '0;
            s_y    <= '0;
        end else begin
            s_de   <= de_r;
            s_sof  <= sof_det;
            s_data <= rgb_r;
            if (de_r) begin
                s_x <= rise ? 10'd0 : s_x + 10'(s_x != 10'h3FF);
                if (rise)
                    s_y <= sof_det ? 10'd0 : s_y + 10'(s_y != 10'h3FF);
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst)
            state <= SEARCH;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEARCH:  state_nx = sof_det ? TRAIN : SEARCH;
            TRAIN:   state_nx = (sof_det & fresh & ~frame_bad) ? LOCKED : TRAIN;
            LOCKED:  state_nx = drop_lock ? TRAIN : LOCKED;
            default: state_nx = SEARCH;
        endcase
    end

    always_comb begin
        locked = state == LOCKED;
    end

    // fresh: training began at a SOF, so this frame may establish the reference
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            fresh       <= 1'b0;
            need_w      <= 1'b0;
            frame_bad   <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            if (drop_lock)
                err_cnt <= err_cnt + ERR_W'(~&err_cnt);
            if (sof_det) begin
                frame_cnt <= frame_cnt + 16'd1;
                fresh     <= 1'b1;
                need_w    <= 1'b1;
                frame_bad <= 1'b0;
                if (state == TRAIN && fresh)
                    meas_height <= height;
            end else if (fall) begin
                if (state == TRAIN && fresh) begin
                    if (need_w) begin
                        meas_width <= len;
                        need_w     <= 1'b0;
                    end else if (len_bad) begin
                        frame_bad <= 1'b1;
                    end
                end
                if (drop_lock)
                    fresh <= 1'b0;
            end
        end
    end

    // a push into a full buffer lands in the slot being popped the same cycle
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            mem      <= '{default: '0};
            rd       <= 1'b0;
            wr       <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (acc) begin
                mem[wr] <= {s_data, s_x, s_y, s_sof, fall};
                wr      <= ~wr;
            end
            if (pop)
                rd <= ~rd;
            cnt <= cnt + 2'(acc) - 2'(pop);
            if (push & ~acc)
                overflow <= 1'b1;
        end
    end

`ifdef LCD_DE_RX_FRAME_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
        end else if (push & s_sof) begin
            frame_crc <= crc;
            crc       <= acc ? crc_step(16'hFFFF, s_data) : 16'hFFFF;
        end else if (acc) begin
            crc <= crc_step(crc, s_data);
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif
endmodule
